// File: rtl/inspeccion_multicanal.sv
// rtl/inspeccion_multicanal.sv - multichannel product inspection FSMs with reject-streak alarms (optional stats: INSPECT_STATS_EN)
module inspeccion_multicanal #(
  parameter int N_CH     = 2,
  parameter int DWELL    = 4,
  parameter int ALARM_TH = 3,
  parameter int CNT_W    = 8,
  localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     p,
  input  logic [N_CH-1:0]     ri,
  input  logic [N_CH-1:0]     ack,
  output logic [2*N_CH-1:0]   e,
  output logic [2*N_CH-1:0]   y,
  output logic [N_CH-1:0]     alarm,
  output logic                busy
`ifdef INSPECT_STATS_EN
  ,
  input  logic [SEL_W-1:0]    stat_sel,
  output logic [CNT_W-1:0]    acc_cnt,
  output logic [CNT_W-1:0]    rej_cnt
`endif
);

  // State codes double as the visible e field of each channel
  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_INSPECT = 2'b01;
  localparam logic [1:0] S_ACCEPT  = 2'b10;
  localparam logic [1:0] S_REJECT  = 2'b11;

  // Dwell counter holds DWELL-1 down to 0; streak counter holds 0..ALARM_TH
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int ST_W = $clog2(ALARM_TH + 1);

  localparam logic [DW_W-1:0] DW_LOAD = DW_W'(DWELL - 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(ALARM_TH);

  logic [N_CH-1:0] ch_busy;

`ifdef INSPECT_STATS_EN
  logic [N_CH-1:0][CNT_W-1:0] acc_all;
  logic [N_CH-1:0][CNT_W-1:0] rej_all;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    logic [1:0]      st_q, st_d;
    logic [DW_W-1:0] dw_q, dw_d;
    logic [ST_W-1:0] str_q, str_d;
    logic            al_q;
    logic            sample;
    logic            enter_acc;
    logic            enter_rej;
    logic [1:0]      y_ch;

    // The decision is taken in the last INSPECT cycle, with the product still present
    assign sample    = (st_q == S_INSPECT) && p[i] && (dw_q == '0);
    assign enter_acc = sample && ri[i];
    assign enter_rej = sample && !ri[i];

    // Next-state and dwell counter; ack only matters while a decision is held
    always_comb begin
      st_d = st_q;
      dw_d = dw_q;
      case (st_q)
        S_IDLE: begin
          if (p[i]) begin
            st_d = S_INSPECT;
            dw_d = DW_LOAD;
          end
        end
        S_INSPECT: begin
          if (!p[i]) begin
            st_d = S_IDLE;
            dw_d = '0;
          end else if (dw_q != '0) begin
            dw_d = dw_q - DW_W'(1);
          end else begin
            st_d = ri[i] ? S_ACCEPT : S_REJECT;
          end
        end
        S_ACCEPT, S_REJECT: begin
          if (ack[i]) st_d = S_IDLE;
        end
        default: begin
          st_d = S_IDLE;
          dw_d = '0;
        end
      endcase
    end

    // Reject streak saturates at the alarm threshold; an accept clears it
    always_comb begin
      str_d = str_q;
      if (enter_acc) begin
        str_d = '0;
      end else if (enter_rej && (str_q != ST_MAX)) begin
        str_d = str_q + ST_W'(1);
      end
    end

    // Channel state registers; alarm tracks the streak value being stored
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q  <= S_IDLE;
        dw_q  <= '0;
        str_q <= '0;
        al_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        dw_q  <= dw_d;
        str_q <= str_d;
        al_q  <= (str_d == ST_MAX);
      end
    end

    // Handshake code: 01 accept pending, 10 reject pending, 11 transfer cycle
    always_comb begin
      y_ch = 2'b00;
      if (st_q == S_ACCEPT) begin
        y_ch = ack[i] ? 2'b11 : 2'b01;
      end else if (st_q == S_REJECT) begin
        y_ch = ack[i] ? 2'b11 : 2'b10;
      end
    end

    assign e[2*i+1:2*i] = st_q;
    assign y[2*i+1:2*i] = y_ch;
    assign alarm[i]     = al_q;
    assign ch_busy[i]   = (st_q != S_IDLE);

`ifdef INSPECT_STATS_EN
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] rej_q;
    logic             xfer;

    assign xfer = ack[i] && ((st_q == S_ACCEPT) || (st_q == S_REJECT));

    // Decisions are counted only when handed off, so aborted or reset products never count
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc_q <= '0;
        rej_q <= '0;
      end else if (xfer) begin
        if ((st_q == S_ACCEPT) && !(&acc_q)) acc_q <= acc_q + CNT_W'(1);
        if ((st_q == S_REJECT) && !(&rej_q)) rej_q <= rej_q + CNT_W'(1);
      end
    end

    assign acc_all[i] = acc_q;
    assign rej_all[i] = rej_q;
`endif
  end

  assign busy = |ch_busy;

`ifdef INSPECT_STATS_EN
  // Read-out mux; a selector past the last channel reads as zero
  always_comb begin
    acc_cnt = '0;
    rej_cnt = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(stat_sel) == k) begin
        acc_cnt = acc_all[k];
        rej_cnt = rej_all[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_inspeccion_multicanal.sv
// tb/tb_inspeccion_multicanal.sv - directed self-checking bench for inspeccion_multicanal
module tb_inspeccion_multicanal;

  localparam int N_CH     = 2;
  localparam int DWELL    = 4;
  localparam int ALARM_TH = 3;
  localparam int CNT_W    = 8;

  logic              clk;
  logic              rst;
  logic [N_CH-1:0]   p;
  logic [N_CH-1:0]   ri;
  logic [N_CH-1:0]   ack;
  logic [2*N_CH-1:0] e;
  logic [2*N_CH-1:0] y;
  logic [N_CH-1:0]   alarm;
  logic              busy;
`ifdef INSPECT_STATS_EN
  logic [0:0]        stat_sel;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  rej_cnt;
`endif

  int total;
  int bad;

  inspeccion_multicanal #(
    .N_CH(N_CH), .DWELL(DWELL), .ALARM_TH(ALARM_TH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .p(p),
    .ri(ri),
    .ack(ack),
    .e(e),
    .y(y),
    .alarm(alarm),
    .busy(busy)
`ifdef INSPECT_STATS_EN
    ,
    .stat_sel(stat_sel),
    .acc_cnt(acc_cnt),
    .rej_cnt(rej_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full product on channel ch: DWELL INSPECT cycles, decision, ack, back to IDLE
  task automatic inspect_one(input int ch, input logic r, input logic exp_al);
    p[ch]  = 1'b1;
    ri[ch] = r;
    tick();
    check("insp_first", 32'(e[2*ch +: 2]), 32'h1);
    repeat (DWELL - 1) tick();
    check("insp_last", 32'(e[2*ch +: 2]), 32'h1);
    tick();
    p[ch] = 1'b0;
    #1;
    check("decision_e", 32'(e[2*ch +: 2]), r ? 32'h2 : 32'h3);
    check("decision_y", 32'(y[2*ch +: 2]), r ? 32'h1 : 32'h2);
    check("decision_alarm", 32'(alarm[ch]), 32'(exp_al));
    ack[ch] = 1'b1;
    #1;
    check("xfer_y", 32'(y[2*ch +: 2]), 32'h3);
    tick();
    ack[ch] = 1'b0;
    #1;
    check("back_idle", 32'(e[2*ch +: 2]), 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    p     = '0;
    ri    = '0;
    ack   = '0;
`ifdef INSPECT_STATS_EN
    stat_sel = 1'b0;
`endif

    // Reset state
    #2;
    check("rst_e", 32'(e), 32'h0);
    check("rst_y", 32'(y), 32'h0);
    check("rst_alarm", 32'(alarm), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (2) tick();
    rst = 1'b1;

    // Basic accept on channel 0 with cycle-exact timing
    p[0]  = 1'b1;
    ri[0] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("basic_insp_e", 32'(e[1:0]), 32'h1);
      check("basic_insp_y", 32'(y[1:0]), 32'h0);
    end
    check("basic_busy", 32'(busy), 32'h1);
    tick();
    p[0] = 1'b0;
    #1;
    check("basic_acc_e", 32'(e[1:0]), 32'h2);
    check("basic_acc_y", 32'(y[1:0]), 32'h1);
    tick();
    check("basic_hold_e", 32'(e[1:0]), 32'h2);
    tick();
    ack[0] = 1'b1;
    #1;
    check("basic_xfer_y", 32'(y[1:0]), 32'h3);
    tick();
    ack[0] = 1'b0;
    #1;
    check("basic_idle_e", 32'(e[1:0]), 32'h0);
    check("basic_idle_busy", 32'(busy), 32'h0);

    // Abort in the second INSPECT cycle
    p[0]  = 1'b1;
    ri[0] = 1'b0;
    tick();
    tick();
    check("abort_insp2", 32'(e[1:0]), 32'h1);
    p[0] = 1'b0;
    tick();
    check("abort_idle", 32'(e[1:0]), 32'h0);
    check("abort_alarm", 32'(alarm), 32'h0);
`ifdef INSPECT_STATS_EN
    stat_sel = 1'b0;
    #1;
    check("abort_acc0", 32'(acc_cnt), 32'd1);
    check("abort_rej0", 32'(rej_cnt), 32'd0);
`endif

    // Alarm on channel 1: three rejects raise it, an accept clears it
    inspect_one(1, 1'b0, 1'b0);
    inspect_one(1, 1'b0, 1'b0);
    inspect_one(1, 1'b0, 1'b1);
    check("alarm_held_idle", 32'(alarm), 32'h2);
    inspect_one(1, 1'b1, 1'b0);
    check("alarm_cleared", 32'(alarm), 32'h0);

    // Both channels together; ack held during INSPECT must be ignored
    p   = 2'b11;
    ri  = 2'b10;
    ack = 2'b11;
    repeat (3) tick();
    check("conc_ack_ignored", 32'(e), 32'h5);
    ack = 2'b00;
    repeat (2) tick();
    p = 2'b00;
    #1;
    check("conc_e", 32'(e), 32'hB);
    check("conc_y", 32'(y), 32'h6);
    check("conc_busy", 32'(busy), 32'h1);
    ack = 2'b01;
    tick();
    ack = 2'b00;
    #1;
    check("conc_ack0_e", 32'(e), 32'h8);
    check("conc_ack0_busy", 32'(busy), 32'h1);
    ack = 2'b10;
    tick();
    ack = 2'b00;
    #1;
    check("conc_done_e", 32'(e), 32'h0);
    check("conc_done_busy", 32'(busy), 32'h0);

    // Channel 0 now has streak 1; park a second reject and reset mid-handshake
    p[0]  = 1'b1;
    ri[0] = 1'b0;
    repeat (DWELL + 1) tick();
    p[0]   = 1'b0;
    ack[0] = 1'b1;
    #1;
    check("prerst_e", 32'(e[1:0]), 32'h3);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_e", 32'(e), 32'h0);
    check("midrst_y", 32'(y), 32'h0);
    check("midrst_alarm", 32'(alarm), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    tick();
    ack[0] = 1'b0;
    rst    = 1'b1;
    inspect_one(0, 1'b0, 1'b0);
    inspect_one(0, 1'b0, 1'b0);
    inspect_one(0, 1'b0, 1'b1);

`ifdef INSPECT_STATS_EN
    // Statistics read-out after a clean reset
    rst = 1'b0;
    tick();
    rst = 1'b1;
    inspect_one(1, 1'b1, 1'b0);
    inspect_one(1, 1'b0, 1'b0);
    inspect_one(1, 1'b1, 1'b0);
    inspect_one(1, 1'b0, 1'b0);
    inspect_one(1, 1'b1, 1'b0);
    stat_sel = 1'b1;
    #1;
    check("stat_acc1", 32'(acc_cnt), 32'd3);
    check("stat_rej1", 32'(rej_cnt), 32'd2);
    stat_sel = 1'b0;
    #1;
    check("stat_acc0", 32'(acc_cnt), 32'd0);
    check("stat_rej0", 32'(rej_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
